// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Debounces a 2-bit slide-switch word. The raw levels are synchronized
//   through two flops per bit. The synchronized word must then hold one value
//   for DEB_CYCLES consecutive cycles before it is published on sw.
//
//   The two bits are settled as a single word. A change on either bit restarts
//   the count for the whole word, so sw never shows a transient mix of old
//   and new bits.
//
// Parameters
//   DEB_CYCLES : consecutive stable cycles required (legal 2 .. 2**CNT_W-1)
//   CNT_W      : width of the settle counter
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   sw_raw[1:0]: raw, bouncing, asynchronous switch levels
//   sw[1:0]    : debounced switch word (registered)
//   sw_changed : one-cycle pulse in the cycle sw takes a new value (registered)
//   busy       : high while a candidate value is settling (registered)
// ---------------------------------------------------------------------------

// Two-flop synchronizer for one switch bit. s1 may go metastable; only s2
// (q) is used downstream.
module sw_debounce_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

module sw_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw,
  output logic       sw_changed,
  output logic       busy
);

  localparam int NUM_BITS = 2;

  // Terminal count. Settling is done when cnt reaches this value while the
  // candidate is still present on s2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers, one per switch bit
  // -------------------------------------------------------------------------
  logic [NUM_BITS-1:0] s2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_sync
      sw_debounce_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw[gi]),
        .q   (s2[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM and datapath state
  // -------------------------------------------------------------------------
  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] cand, cand_nxt;
  logic [NUM_BITS-1:0] sw_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                chg_nxt;
  logic                busy_nxt;

  logic match_cand;
  logic match_sw;
  logic cnt_done;

  assign match_cand = (s2 == cand);
  assign match_sw   = (s2 == sw);
  // The counter is never allowed past CNT_LAST. The >= form also treats an
  // out-of-range count as done, so the counter cannot walk up to a wrap.
  assign cnt_done   = (cnt >= CNT_LAST);

  // State register. All outputs are taken from flops so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STABLE;
      cand       <= '0;
      cnt        <= '0;
      sw         <= '0;
      sw_changed <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      sw         <= sw_nxt;
      sw_changed <= chg_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      STABLE: begin
        if (!match_sw) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (match_cand) begin
          if (cnt_done) state_nxt = STABLE;
        end else if (match_sw) begin
          // Bounced back to the published value; nothing to settle.
          state_nxt = STABLE;
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  // Datapath / output next-values
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    sw_nxt   = sw;
    chg_nxt  = 1'b0;
    busy_nxt = (state_nxt == SETTLE);

    case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (!match_sw) cand_nxt = s2;
      end
      SETTLE: begin
        if (match_cand) begin
          if (cnt_done) begin
            sw_nxt  = cand;
            chg_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          // Either a bounce back to sw or a different new value. Both
          // discard progress. A new value becomes the candidate.
          cnt_nxt = '0;
          if (!match_sw) cand_nxt = s2;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboarded bench for sw_debounce. Two instances share one sw_raw stream:
// instance a with DEB_CYCLES=4 and instance b with DEB_CYCLES=2.
//
// The reference model works on the sampled input stream. The FSM sees the
// raw value from two edges earlier. sw takes value v at an edge when the last
// DEB+1 samples all equal v and v differs from the current sw. busy is high
// when the latest sample differs from sw.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_a, sw_b;
  logic       chg_a, chg_b, busy_a, busy_b;

  always #5 clk = ~clk;

  sw_debounce #(.DEB_CYCLES(4), .CNT_W(20)) u_a (
    .clk(clk), .rst(rst), .sw_raw(sw_raw),
    .sw(sw_a), .sw_changed(chg_a), .busy(busy_a)
  );

  sw_debounce #(.DEB_CYCLES(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .sw_raw(sw_raw),
    .sw(sw_b), .sw_changed(chg_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  bit run   = 1'b0;

  typedef struct {
    int         e;
    logic [1:0] v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Model state: delay line, current run of equal samples, and the
  // published value for each instance.
  int         deb [2] = '{4, 2};
  logic [1:0] d1, d2, rv;
  int         rl;
  logic [1:0] msw   [2];
  logic       mbusy [2];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, req, ecnt);
    end
  endtask

  task automatic model_reset();
    d1 = 2'b00; d2 = 2'b00; rv = 2'b00; rl = 1;
    for (int i = 0; i < 2; i++) begin
      msw[i]   = 2'b00;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [1:0] v);
    logic [1:0] s;
    exp_t       x;
    s  = d2;
    d2 = d1;
    d1 = v;
    if (s == rv) rl++;
    else begin
      rv = s;
      rl = 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (rl >= deb[i] + 1 && rv != msw[i]) begin
        msw[i] = rv;
        x.e = ecnt;
        x.v = rv;
        if (i == 0) qa.push_back(x);
        else        qb.push_back(x);
      end
      mbusy[i] = (s != msw[i]);
    end
  endtask

  // One clock: drive the input, take the edge, advance the model, and park
  // at negedge+1 ready for the next drive.
  task automatic cyc(input logic [1:0] v);
    sw_raw = v;
    @(posedge clk);
    ecnt++;
    model_step(v);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  // Monitor: levels compared every cycle. Pulses are matched against the
  // scoreboard queues.
  always @(negedge clk) begin
    if (run) begin
      exp_t x;
      chk("sw_a", sw_a, msw[0]);
      chk("busy_a", busy_a, mbusy[0]);
      chk("sw_b", sw_b, msw[1]);
      chk("busy_b", busy_b, mbusy[1]);
      chk("cnt_b_le1", (u_b.cnt <= 2'd1), 1);

      if (chg_a) begin
        if (qa.size() == 0) chk("chg_a_unexpected", chg_a, 0);
        else begin
          x = qa.pop_front();
          chk("chg_a_edge", ecnt, x.e);
          chk("chg_a_val", sw_a, x.v);
        end
      end else if (qa.size() != 0 && qa[0].e <= ecnt) begin
        x = qa.pop_front();
        chk("chg_a_missing", chg_a, 1);
      end

      if (chg_b) begin
        if (qb.size() == 0) chk("chg_b_unexpected", chg_b, 0);
        else begin
          x = qb.pop_front();
          chk("chg_b_edge", ecnt, x.e);
          chk("chg_b_val", sw_b, x.v);
        end
      end else if (qb.size() != 0 && qb[0].e <= ecnt) begin
        x = qb.pop_front();
        chk("chg_b_missing", chg_b, 1);
      end
    end
  end

  initial begin
    model_reset();
    // Reset with a nonzero input. The synchronizer must stay cleared.
    rst    = 1'b1;
    sw_raw = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw_a", sw_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_chg_a", chg_a, 0);
    chk("rst_sw_b", sw_b, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run = 1'b1;

    // Release with the input nonzero, then settle back to 00.
    hold(2'b11, 10);
    hold(2'b00, 10);
    // Clean change
    hold(2'b01, 10);
    hold(2'b00, 10);
    // Glitch reject: too short for a, long enough for b
    hold(2'b10, 3);
    hold(2'b00, 10);
    // Short glitch rejected by both instances
    hold(2'b10, 2);
    hold(2'b00, 10);
    // Retarget 01 -> 11
    hold(2'b01, 2);
    hold(2'b11, 10);
    hold(2'b00, 10);
    // Back-to-back changes
    hold(2'b11, 8);
    hold(2'b10, 10);
    hold(2'b00, 10);

    // Asynchronous reset while settling
    hold(2'b01, 4);
    chk("pre_rst_busy_a", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("arst_sw_a", sw_a, 0);
    chk("arst_busy_a", busy_a, 0);
    chk("arst_chg_a", chg_a, 0);
    chk("arst_busy_b", busy_b, 0);
    #1;
    rst = 1'b0;
    model_reset();
    hold(2'b01, 10);
    hold(2'b00, 10);

    // Random bouncing
    for (int k = 0; k < 60; k++) begin
      logic [1:0] v;
      int         n;
      v = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 9);
      hold(v, n);
    end
    hold(2'b00, 12);

    run = 1'b0;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000, meaning the number of consecutive stable cycles required before an output change; legal range 2..2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the width of the settle counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port sw_raw, input, 2 bits: raw slide-switch levels, asynchronous to clk and bouncing.
REQ-006 The block SHALL have port sw, output, 2 bits: the debounced switch value, driving the LED pattern stage's mode input directly.
REQ-007 The block SHALL have port sw_changed, output, 1 bit: a single-cycle pulse in the cycle sw takes a new value.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in state SETTLE.

Function
REQ-009 sw_raw SHALL pass through a 2-stage flip-flop synchronizer (s1, then s2); only s2 SHALL feed the rest of the logic.
REQ-010 The block SHALL have an FSM with two states, STABLE and SETTLE, a 2-bit candidate register cand, and a CNT_W-bit counter cnt.
REQ-011 In STABLE with s2 == sw, the block SHALL hold its state, with cnt = 0 and sw_changed = 0.
REQ-012 In STABLE with s2 != sw, the block SHALL capture cand <= s2, set cnt <= 0 and move to SETTLE.
REQ-013 In SETTLE with s2 == cand and cnt < DEB_CYCLES-1, the block SHALL increment cnt by 1.
REQ-014 In SETTLE with s2 == cand and cnt == DEB_CYCLES-1, the block SHALL load sw <= cand, pulse sw_changed = 1 for that cycle, clear cnt and return to STABLE.
REQ-015 In SETTLE with s2 != cand and s2 == sw (bounce back to the old value), the block SHALL return to STABLE with cnt <= 0, leave sw unchanged and not pulse sw_changed.
REQ-016 In SETTLE with s2 != cand and s2 != sw (a different new value), the block SHALL load cand <= s2, set cnt <= 0 and remain in SETTLE.
REQ-017 Latency: if sw_raw changes to a steady value before clock edge k, sw SHALL take that value at edge k+DEB_CYCLES+2, and sw_changed SHALL be high for exactly the cycle following that edge.
REQ-018 sw SHALL never take any value other than one that has held on s2 for DEB_CYCLES consecutive cycles.
REQ-019 Both bits SHALL be debounced as one 2-bit word; a change to either bit SHALL restart settling for the whole word.
REQ-020 The cnt arithmetic SHALL be unsigned and SHALL never wrap; cnt SHALL never exceed DEB_CYCLES-1.
REQ-021 sw_changed and busy SHALL be registered outputs, driven glitch-free from flip-flops.

Reset
REQ-022 When rst is asserted, all state SHALL clear immediately, regardless of clk: s1 = s2 = 0, cand = 0, cnt = 0, state = STABLE, sw = 2'b00, sw_changed = 0, busy = 0.
REQ-023 If rst is asserted mid-SETTLE, the pending candidate SHALL be discarded and sw SHALL read 2'b00 while rst is high.
REQ-024 After rst deasserts with sw_raw nonzero, the block SHALL debounce normally from 00, and sw SHALL reach sw_raw after DEB_CYCLES+2 edges.

Verification (DEB_CYCLES=4)
REQ-025 Clean change: sw_raw 00->01 before edge 0 and held -> sw = 01 after edge 6; sw_changed high for one cycle; busy high from edge 2 to edge 6.
REQ-026 Glitch reject: sw_raw 00->10 for 3 cycles, then back to 00 -> sw stays 00; sw_changed is never asserted; busy returns low.
REQ-027 Retarget: sw_raw 00->01 for 2 cycles, then 11 held -> sw goes 00->11 directly, never showing 01; one sw_changed pulse.
REQ-028 Async reset mid-SETTLE: rst pulsed between edges while busy = 1 -> sw = 00 and busy = 0 before the next edge; no sw_changed.
REQ-029 Back-to-back changes: 00->11 held 8 cycles, then 11->10 held -> two sw_changed pulses, 6 edges after each change; sw sequence 00, 11, 10.
REQ-030 Parameter edge case: DEB_CYCLES=2 with a clean change -> sw updates 4 edges after the change; cnt never exceeds 1.
